ucode_seq: RTL
==============

UCODE_SEQ -- requirements
Module: ucode_seq

Interface
REQ-001 SHALL have parameter PROM_LAT, default 1, giving the number of cycles from addr change to valid q at the microcode PROM.
REQ-002 SHALL have port c, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port r, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: one-cycle request to run a microprogram.
REQ-005 SHALL have port entry, input, 7 bits: PROM entry address; 0x00 runs the current-sense update and 0x7c runs the integrator reset.
REQ-006 SHALL have port addr, output, 7 bits: registered PROM address.
REQ-007 SHALL have port q, input, 32 bits: PROM word, laid out as {op[31:24], a[23:16], b[15:8], d[7:0]}.
REQ-008 SHALL have port op_valid, output, 1 bit: an instruction is offered to the execution unit.
REQ-009 SHALL have port op_ready, input, 1 bit: the execution unit accepts the offered instruction.
REQ-010 SHALL have ports op, a, b and d, outputs, 8 bits each: the registered fields of the offered instruction.
REQ-011 SHALL have port busy, output, 1 bit: a microprogram is running.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on HALT.
REQ-013 SHALL have port fault, output, 1 bit: one-cycle pulse when the address would wrap.
REQ-014 SHALL have port icount, output, 8 bits: number of instructions dispatched in the current or last run.

Function
REQ-015 SHALL implement the states IDLE, ADDR, WAIT, ISSUE and END.
REQ-016 In IDLE, start SHALL load pc=entry, drive addr=entry, clear icount and go to ADDR; while busy, start SHALL be ignored.
REQ-017 ADDR SHALL hold addr=pc for PROM_LAT cycles; WAIT SHALL then capture q into the instruction register (op/a/b/d).
REQ-018 After WAIT, if op equals OP_NOP, the block SHALL skip dispatch, set pc=pc+1 and return to ADDR.
REQ-019 After WAIT, if op equals OP_HALT, the block SHALL go to END without asserting op_valid.
REQ-020 After WAIT, for any other op, the block SHALL go to ISSUE.
REQ-021 In ISSUE, op_valid SHALL be 1, and op/a/b/d SHALL stay stable until the cycle in which op_valid and op_ready are both 1.
REQ-022 On the ISSUE handshake, the block SHALL increment icount (saturating at 0xFF), set pc=pc+1 and go to ADDR.
REQ-023 Maximum throughput SHALL be one instruction per PROM_LAT+2 cycles; prefetch is not required.
REQ-024 When pc=0x7f and the instruction is not HALT, then on advance the block SHALL pulse fault, perform no wrap to 0x00, and go to END.
REQ-025 END SHALL pulse done (HALT) or fault (wrap) for exactly one cycle, deassert busy, and return to IDLE in the next cycle.
REQ-026 busy SHALL be 1 in ADDR, WAIT and ISSUE, and 0 in IDLE and END.
REQ-027 Operand fields SHALL pass through unmodified, including x/don't-care bytes; no decoding beyond the NOP/HALT compare.
REQ-028 A start arriving in the same cycle as done SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-029 When r=1, the block SHALL go to IDLE with addr=0, pc=0, op/a/b/d=0, op_valid=0, busy=0, done=0, fault=0 and icount=0.
REQ-030 Reset during ISSUE SHALL drop op_valid in the next cycle, discard the offered instruction, and generate no done and no fault.

Structure
REQ-031 The opcode constants (OP_NOP, OP_HALT, and the arithmetic/IO opcodes) SHALL come from the shared ops definitions; no local opcode literals.
REQ-032 The entry addresses (ENTRY_CUR_UPDATE=0x00, ENTRY_INT_RESET=0x7c) SHALL be defined in the same shared definitions.
REQ-033 The block SHALL be a single module with no sub-module; the PROM is instantiated beside it by the parent.

Verification
REQ-034 start, entry=0x7c, op_ready tied 1 -> exactly 2 ADD dispatches (d=0x10, then d=0x11), then done pulse, icount=2, busy low.
REQ-035 start, entry=0x00, op_ready tied 1 -> first dispatch is op=OP_IN, a=0x00, d=0x00; the NOP at 0x00 is never offered; run ends with done.
REQ-036 op_ready held 0 for 5 cycles during ISSUE -> op_valid and fields stay stable for all 5 cycles; exactly one dispatch is counted.
REQ-037 Stub PROM with non-HALT at 0x7e and 0x7f, entry=0x7e -> 2 dispatches, fault pulse, no done, addr never equals 0x00.
REQ-038 r pulsed mid-ISSUE, then start entry=0x7c -> all outputs return to reset values; the second run completes normally with icount=2.
REQ-039 start repeated while busy, and start in the same cycle as done -> both ignored; no restart and no change to icount.

Source files
------------

// File: rtl/ucode_seq_pkg.sv
// Shared microcode definitions: opcodes, entry points, sequencer states.
// Instruction word layout is {op, a, b, d}, one byte each.
package ucode_seq_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_SUB  = 8'h02;
  localparam logic [7:0] OP_MUL  = 8'h03;
  localparam logic [7:0] OP_IN   = 8'h10;
  localparam logic [7:0] OP_OUT  = 8'h11;
  localparam logic [7:0] OP_HALT = 8'hff;

  localparam logic [6:0] ENTRY_CUR_UPDATE = 7'h00;
  localparam logic [6:0] ENTRY_INT_RESET  = 7'h7c;
  localparam logic [6:0] PC_LAST          = 7'h7f;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_END   = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
  } insn_t;

endpackage

// File: rtl/ucode_seq.sv
// Microcode sequencer: fetches words from an external PROM and offers
// each non-NOP, non-HALT instruction to an execution unit.
module ucode_seq
  import ucode_seq_pkg::*;
#(
  parameter int PROM_LAT = 1
) (
  input  logic       c,
  input  logic       r,
  input  logic       start,
  input  logic [6:0] entry,
  output logic [6:0] addr,
  input  logic [31:0] q,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [7:0] op,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] d,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [7:0] icount,
  output state_e     dbg_state
);

  localparam logic [7:0] LAT_LAST = 8'(PROM_LAT - 1);

  state_e     state_q, state_d;
  logic [6:0] pc_q, pc_d;
  logic [6:0] addr_q, addr_d;
  insn_t      ir_q, ir_d;
  logic [7:0] icount_q, icount_d;
  logic [7:0] lat_q, lat_d;
  logic       done_q, done_d;
  logic       fault_q, fault_d;
  logic       advance;
  insn_t      q_word;

  assign q_word = insn_t'(q);

  always_ff @(posedge c) begin
    if (r) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      addr_q   <= '0;
      ir_q     <= '0;
      icount_q <= '0;
      lat_q    <= '0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      ir_q     <= ir_d;
      icount_q <= icount_d;
      lat_q    <= lat_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
    end
  end

  // Handshake: op_valid rises in ISSUE and holds op/a/b/d steady; the
  // instruction is consumed on the first rising edge where op_valid && op_ready.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    icount_d = icount_q;
    lat_d    = lat_q;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    advance  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d     = entry;
          addr_d   = entry;
          icount_d = '0;
          lat_d    = '0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (lat_q == LAT_LAST) state_d = ST_WAIT;
        else                   lat_d   = lat_q + 8'd1;
      end
      ST_WAIT: begin
        ir_d = q_word;
        if (q_word.op == OP_HALT) begin
          state_d = ST_END;
          done_d  = 1'b1;
        end else if (q_word.op == OP_NOP) begin
          advance = 1'b1;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_ready) begin
          icount_d = (icount_q == 8'hff) ? icount_q : icount_q + 8'd1;
          advance  = 1'b1;
        end
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Stepping past the last PROM word aborts rather than wrapping to 0x00.
    if (advance) begin
      if (pc_q == PC_LAST) begin
        state_d = ST_END;
        fault_d = 1'b1;
      end else begin
        pc_d    = pc_q + 7'd1;
        addr_d  = pc_q + 7'd1;
        lat_d   = '0;
        state_d = ST_ADDR;
      end
    end
  end

  assign addr      = addr_q;
  assign op        = ir_q.op;
  assign a         = ir_q.a;
  assign b         = ir_q.b;
  assign d         = ir_q.d;
  assign op_valid  = (state_q == ST_ISSUE);
  assign busy      = (state_q == ST_ADDR) || (state_q == ST_WAIT) || (state_q == ST_ISSUE);
  assign done      = done_q;
  assign fault     = fault_q;
  assign icount    = icount_q;
  assign dbg_state = state_q;

endmodule
